// File: rtl/start_done_pkg.sv
// Shared types for the start/done launcher: FSM states, response status codes and field widths.
package start_done_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StBackoff,
    StReport
  } state_e;

  typedef enum logic [1:0] {
    StatusOk      = 2'd0,
    StatusTimeout = 2'd1,
    StatusAbort   = 2'd2
  } resp_status_e;

  localparam int unsigned TRIES_W = 4;
  localparam logic [TRIES_W-1:0] TRIES_MAX = '1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/launch_watchdog.sv
// Clearable up-counter with a terminal-count compare; timed both the done watchdog and the backoff.
module launch_watchdog #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [Width-1:0] term_i,
  output logic [Width-1:0] cnt_o,
  output logic             hit_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/start_done_launcher.sv
// Launches a worker job with a one-cycle start pulse, watches done against a timeout with
// bounded retries and backoff, and returns one status response per accepted request.
module start_done_launcher
  import start_done_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned BACKOFF   = 4,
  parameter int unsigned CW        = $clog2(TIMEOUT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               abort_i,
  output logic               start_o,
  input  logic               done_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [1:0]         resp_status_o,
  output logic [TRIES_W-1:0] resp_tries_o,
  output logic [CW-1:0]      resp_cycles_o,
  output logic               busy_o
);

  // The counter is shared with the backoff wait, so it must also hold BACKOFF-1.
  localparam int unsigned BW   = (BACKOFF > 0) ? $clog2(BACKOFF + 1) : 1;
  localparam int unsigned CntW = max_u(CW, BW);
  localparam logic [CntW-1:0] TermWait    = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] TermBackoff = (BACKOFF > 0) ? CntW'(BACKOFF - 1) : '0;
  localparam logic [TRIES_W-1:0] MaxRetry = TRIES_W'(MAX_RETRY);

  state_e             state_q, state_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  resp_status_e       resp_status_q, resp_status_d;
  logic [TRIES_W-1:0] resp_tries_q, resp_tries_d;
  logic [CW-1:0]      resp_cycles_q, resp_cycles_d;

  logic            cnt_clr, cnt_inc, cnt_hit;
  logic [CntW-1:0] cnt, cnt_term;
  logic            report;
  resp_status_e    rep_status;
  logic [CW-1:0]   rep_cycles;

  assign cnt_term = (state_q == StBackoff) ? TermBackoff : TermWait;

  launch_watchdog #(
    .Width(CntW)
  ) u_watchdog (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .term_i(cnt_term),
    .cnt_o (cnt),
    .hit_o (cnt_hit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      tries_q       <= '0;
      resp_status_q <= StatusOk;
      resp_tries_q  <= '0;
      resp_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      tries_q       <= tries_d;
      resp_status_q <= resp_status_d;
      resp_tries_q  <= resp_tries_d;
      resp_cycles_q <= resp_cycles_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tries_d       = tries_q;
    resp_status_d = resp_status_q;
    resp_tries_d  = resp_tries_q;
    resp_cycles_d = resp_cycles_q;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    report        = 1'b0;
    rep_status    = StatusOk;
    rep_cycles    = '0;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d = StLaunch;
          tries_d = '0;
        end
      end
      StLaunch: begin
        cnt_clr = 1'b1;
        if (tries_q != TRIES_MAX) begin
          tries_d = tries_q + 1'b1;
        end
        if (abort_i) begin
          report     = 1'b1;
          rep_status = StatusAbort;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_inc = 1'b1;
        // Priority: abort over done, done over timeout.
        if (abort_i) begin
          report     = 1'b1;
          rep_status = StatusAbort;
        end else if (done_i) begin
          report     = 1'b1;
          rep_status = StatusOk;
          rep_cycles = CW'(cnt + 1'b1);
        end else if (cnt_hit) begin
          if (tries_q <= MaxRetry) begin
            cnt_clr = 1'b1;
            state_d = (BACKOFF == 0) ? StLaunch : StBackoff;
          end else begin
            report     = 1'b1;
            rep_status = StatusTimeout;
          end
        end
      end
      StBackoff: begin
        cnt_inc = 1'b1;
        if (abort_i) begin
          report     = 1'b1;
          rep_status = StatusAbort;
        end else if (cnt_hit) begin
          state_d = StLaunch;
        end
      end
      StReport: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (report) begin
      state_d       = StReport;
      resp_status_d = rep_status;
      resp_tries_d  = tries_d;
      resp_cycles_d = rep_cycles;
    end
  end

  always_comb begin
    req_ready_o   = (state_q == StIdle);
    start_o       = (state_q == StLaunch);
    resp_valid_o  = (state_q == StReport);
    busy_o        = (state_q != StIdle);
    resp_status_o = resp_status_q;
    resp_tries_o  = resp_tries_q;
    resp_cycles_o = resp_cycles_q;
  end

  a_start_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    start_o |=> !start_o);
  a_resp_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    resp_valid_o && !resp_ready_i |=> resp_valid_o);
  a_resp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    resp_valid_o && !resp_ready_i |=> $stable({resp_status_o, resp_tries_o, resp_cycles_o}));

endmodule

// File: tb/tb_start_done_launcher.sv
// Randomized bench for start_done_launcher: three configurations, a job-level reference model
// feeding a per-instance scoreboard, and a monitor that checks responses and start spacing.
module tb_start_done_launcher;

  typedef struct {
    int status;
    int tries;
    int cycles;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int gi, input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL g%0d %s: got %0d want %0d", gi, name, act, want);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int T   = (g == 0) ? 10 : (g == 1) ? 6 : 5;
    localparam int MR  = (g == 0) ? 2 : (g == 1) ? 1 : 0;
    localparam int BO  = (g == 0) ? 4 : (g == 1) ? 0 : 3;
    localparam int CWG = $clog2(T + 1);

    logic           rst_n, req_valid, req_ready, abort, start, done;
    logic           resp_valid, resp_ready, busy, fin;
    logic [1:0]     resp_status;
    logic [3:0]     resp_tries;
    logic [CWG-1:0] resp_cycles;
    exp_t           q[$];

    start_done_launcher #(
      .TIMEOUT  (T),
      .MAX_RETRY(MR),
      .BACKOFF  (BO)
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .abort_i      (abort),
      .start_o      (start),
      .done_i       (done),
      .resp_valid_o (resp_valid),
      .resp_ready_i (resp_ready),
      .resp_status_o(resp_status),
      .resp_tries_o (resp_tries),
      .resp_cycles_o(resp_cycles),
      .busy_o       (busy)
    );

    // Walks attempts on a timeline relative to each start (t=0 is the start cycle).
    function automatic exp_t model(input int dly[16], input int ab_att, input int ab_t);
      exp_t e;
      e = '{1, 15, 0, T + 1};
      for (int a = 1; a < 16; a++) begin
        int at;
        int d;
        at = (ab_att == a) ? ab_t : -1;
        d  = (dly[a] >= 1 && dly[a] <= T) ? dly[a] : -1;
        if (at == 0) return '{2, a, 0, 1};
        if (d > 0 && (at < 0 || d < at)) return '{0, a, d, d + 1};
        if (at > 0 && at <= T) return '{2, a, 0, at + 1};
        if (a > MR) return '{1, a, 0, T + 1};
        if (at > T && at <= T + BO) return '{2, a, 0, at + 1};
      end
      return e;
    endfunction

    initial begin : driver
      int   dly[16];
      int   ab_att, ab_t, stall, att, t;
      bit   got;
      exp_t e;
      fin = 1'b0; rst_n = 1'b0; req_valid = 1'b0; abort = 1'b0; done = 1'b0; resp_ready = 1'b0;
      #2;
      chk(g, "rst_ctrl", int'({req_ready, start, resp_valid, busy}), 8);
      chk(g, "rst_fields", int'({resp_status, resp_tries, resp_cycles}), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int j = 0; j < 48; j++) begin
        foreach (dly[i]) dly[i] = 0;
        ab_att = 0; ab_t = 0; stall = 0;
        case (j)
          0: begin dly[1] = 3; stall = 5; end
          1: ;
          2: begin dly[1] = T + 2; dly[2] = 5; end
          3: dly[1] = T;
          4: begin dly[1] = 4; ab_att = 1; ab_t = 4; end
          5: begin ab_att = 1; ab_t = 0; end
          6: begin ab_att = 1; ab_t = T + 2; stall = 5; end
          default: begin
            for (int a = 1; a < 16; a++)
              dly[a] = ($urandom_range(0, 9) < 4) ? 0 : int'($urandom_range(1, T + BO + 1));
            if ($urandom_range(0, 3) == 0) begin
              ab_att = int'($urandom_range(1, MR + 1));
              ab_t   = int'($urandom_range(0, T + BO));
            end
            if ($urandom_range(0, 4) == 0) stall = 5;
          end
        endcase
        if (j == 7) begin
          // Drop a job mid-WAIT with reset; no response may follow.
          req_valid = 1'b1;
          @(posedge clk); #1;
          req_valid = 1'b0;
          repeat (3) begin @(posedge clk); #1; end
          #2 rst_n = 1'b0;
          #1;
          chk(g, "midrst_ctrl", int'({req_ready, start, resp_valid, busy}), 8);
          chk(g, "midrst_fields", int'({resp_status, resp_tries, resp_cycles}), 0);
          @(negedge clk);
          @(posedge clk); #1;
          rst_n = 1'b1;
        end
        e = model(dly, ab_att, ab_t);
        q.push_back(e);
        req_valid = 1'b1;
        abort = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        req_valid = 1'b0; abort = 1'b0;
        att = 0; t = 0; got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
          if (start) begin att++; t = 0; end
          done  = (att > 0 && att < 16 && t > 0) ? (dly[(att > 0 && att < 16) ? att : 0] == t) : 1'b0;
          abort = (att > 0 && att == ab_att && t == ab_t);
          if (resp_valid) begin
            done = 1'($urandom_range(0, 1));
            abort = 1'($urandom_range(0, 1));
            resp_ready = (stall > 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (stall > 0) stall--;
            got = resp_ready;
          end else begin
            resp_ready = 1'($urandom_range(0, 1));
          end
          @(posedge clk); #1;
          t++;
        end
        done = 1'b0; abort = 1'b0; resp_ready = 1'b0;
        if (!got) begin
          chk(g, "job_timeout", 0, 1);
          rst_n = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1;
          q.delete();
        end
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      repeat (4) begin @(posedge clk); #1; end
      chk(g, "resp_missing", q.size(), 0);
      fin = 1'b1;
    end

    initial begin : monitor
      exp_t e;
      int   st_s, tr_s, cy_s, n_start, last_start;
      bit   in_resp, hs_prev;
      st_s = 0; tr_s = 0; cy_s = 0; n_start = 0; last_start = 0; in_resp = 0; hs_prev = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          n_start = 0; in_resp = 0; hs_prev = 0;
        end else begin
          if (hs_prev) begin
            chk(g, "resp_release", int'(resp_valid), 0);
            chk(g, "idle_hold_status", int'(resp_status), st_s);
            chk(g, "idle_hold_tries", int'(resp_tries), tr_s);
            in_resp = 0; hs_prev = 0;
          end
          if (start) begin
            if (n_start > 0) chk(g, "start_gap", cyc - last_start, 1 + T + BO);
            n_start++;
            last_start = cyc;
          end
          if (resp_valid) begin
            if (!in_resp) begin
              in_resp = 1;
              if (q.size() == 0) begin
                chk(g, "unexpected_resp", 1, 0);
              end else begin
                e = q.pop_front();
                chk(g, "status", int'(resp_status), e.status);
                chk(g, "tries", int'(resp_tries), e.tries);
                chk(g, "cycles", int'(resp_cycles), e.cycles);
                chk(g, "start_count", n_start, e.tries);
                chk(g, "latency", cyc - last_start, e.lat);
                chk(g, "ready_busy_in_report", int'({req_ready, busy}), 1);
              end
              st_s = int'(resp_status); tr_s = int'(resp_tries); cy_s = int'(resp_cycles);
            end else begin
              chk(g, "resp_stable", int'({resp_status, resp_tries, resp_cycles}),
                  (st_s << (4 + CWG)) | (tr_s << CWG) | cy_s);
            end
            if (resp_ready) begin
              hs_prev = 1;
              n_start = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 60000 && !(g_dut[0].fin && g_dut[1].fin && g_dut[2].fin); i++)
      @(posedge clk);
    if (!(g_dut[0].fin && g_dut[1].fin && g_dut[2].fin)) chk(9, "global_timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
